// File: rtl/cpu_defs.sv
// Shared encodings for the execute stage: ALU op select, PC source select, EX FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BEQ = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } ex_state_t;

    // One EX/MEM pipeline register entry; all-zero is a bubble.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        taken;
        logic [31:0] target;
    } exmem_t;

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, WB forwarding inputs, flush/stall and EX/MEM outputs.
// Latency: wires only.
// Backpressure: Stall travels from the slave (EX) back to the master (ID side).
interface ex_stage_if;

    logic [31:0] PCPlus4;
    logic [31:0] ReadDataRF0;
    logic [31:0] ReadDataRF1;
    logic [31:0] SignExtended;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [25:0] JumpAddress;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        MemToReg;
    logic        RegDst;
    logic        ALUSrc;
    logic [2:0]  ALUControl;
    logic [1:0]  PCSrc;
    logic        WBRegWrite;
    logic [4:0]  WBWriteReg;
    logic [31:0] WBWriteData;
    logic        Flush;

    logic        Stall;
    logic [31:0] ALUResultOut;
    logic [31:0] WriteDataOut;
    logic [4:0]  WriteRegOut;
    logic        RegWriteOut;
    logic        MemReadOut;
    logic        MemWriteOut;
    logic        MemToRegOut;
    logic        TakenOut;
    logic [31:0] TargetOut;

    modport master (
        output PCPlus4, ReadDataRF0, ReadDataRF1, SignExtended, Rs, Rt, Rd, JumpAddress,
               RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, ALUControl, PCSrc,
               WBRegWrite, WBWriteReg, WBWriteData, Flush,
        input  Stall, ALUResultOut, WriteDataOut, WriteRegOut, RegWriteOut, MemReadOut,
               MemWriteOut, MemToRegOut, TakenOut, TargetOut
    );

    modport slave (
        input  PCPlus4, ReadDataRF0, ReadDataRF1, SignExtended, Rs, Rt, Rd, JumpAddress,
               RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc, ALUControl, PCSrc,
               WBRegWrite, WBWriteReg, WBWriteData, Flush,
        output Stall, ALUResultOut, WriteDataOut, WriteRegOut, RegWriteOut, MemReadOut,
               MemWriteOut, MemToRegOut, TakenOut, TargetOut
    );

endinterface

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier, low 32 bits of the unsigned product.
// Latency: 32 steps after the start edge; done is high during the final step.
// Backpressure: none; abort cancels a run synchronously, start is ignored while aborting.
module mul_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic        busy_q;

    // Operand latch on start, then one shift-add step per cycle for 32 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (b_q[0]) begin
                acc_q <= acc_q + a_q;
            end
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_q <= 1'b0;
            end
        end
    end

    // done marks the cycle performing step 31, so the product is final after this edge.
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == 5'd31);
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU/iterative MUL, beq/j resolution, EX/MEM register.
// Latency: 1 cycle for single-cycle ops; MUL lands 34 cycles after it is presented.
// Backpressure: Stall (combinational) holds upstream for the 33 cycles a MUL occupies EX.
module ex_stage
    import cpu_defs::*;
(
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);

    exmem_t      exmem_q;
    exmem_t      exmem_d;
    exmem_t      exmem_live;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] b_op;
    logic [31:0] alu_res;
    logic        br_taken;
    logic [31:0] br_target;
    ex_state_t   state;
    ex_state_t   state_nxt;
    logic        stall_raw;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;

    // Operand forwarding: EX/MEM result beats WB value beats register file; r0 never forwarded.
    always_comb begin
        fwd_a = bus.ReadDataRF0;
        if (exmem_q.reg_write && exmem_q.write_reg != 5'd0 && exmem_q.write_reg == bus.Rs) begin
            fwd_a = exmem_q.alu_result;
        end else if (bus.WBRegWrite && bus.WBWriteReg != 5'd0 && bus.WBWriteReg == bus.Rs) begin
            fwd_a = bus.WBWriteData;
        end
        fwd_b = bus.ReadDataRF1;
        if (exmem_q.reg_write && exmem_q.write_reg != 5'd0 && exmem_q.write_reg == bus.Rt) begin
            fwd_b = exmem_q.alu_result;
        end else if (bus.WBRegWrite && bus.WBWriteReg != 5'd0 && bus.WBWriteReg == bus.Rt) begin
            fwd_b = bus.WBWriteData;
        end
    end

    assign b_op = bus.ALUSrc ? bus.SignExtended : fwd_b;

    // Single-cycle ALU; MUL and unused encodings produce 0 here.
    always_comb begin
        alu_res = '0;
        case (bus.ALUControl)
            ALU_AND: alu_res = fwd_a & b_op;
            ALU_OR:  alu_res = fwd_a | b_op;
            ALU_ADD: alu_res = fwd_a + b_op;
            ALU_SUB: alu_res = fwd_a - b_op;
            ALU_SLT: alu_res = {31'd0, ($signed(fwd_a) < $signed(b_op))};
            default: alu_res = '0;
        endcase
    end

    // Branch/jump resolution; beq compares the forwarded register operands.
    always_comb begin
        br_taken  = 1'b0;
        br_target = '0;
        case (bus.PCSrc)
            PC_BEQ: begin
                if (fwd_a == fwd_b) begin
                    br_taken  = 1'b1;
                    br_target = bus.PCPlus4 + (bus.SignExtended << 2);
                end
            end
            PC_J: begin
                br_taken  = 1'b1;
                br_target = {bus.PCPlus4[31:28], bus.JumpAddress, 2'b00};
            end
            default: begin
                br_taken  = 1'b0;
                br_target = '0;
            end
        endcase
    end

    // EX/MEM entry for the instruction currently held in ID/EX.
    always_comb begin
        exmem_live.alu_result = alu_res;
        exmem_live.write_data = fwd_b;
        exmem_live.write_reg  = bus.RegDst ? bus.Rd : bus.Rt;
        exmem_live.reg_write  = bus.RegWrite;
        exmem_live.mem_read   = bus.MemRead;
        exmem_live.mem_write  = bus.MemWrite;
        exmem_live.mem_to_reg = bus.MemToReg;
        exmem_live.taken      = br_taken;
        exmem_live.target     = br_target;
    end

    mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (bus.Flush),
        .a       (fwd_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and EX/MEM load selection; Flush always wins and loads a bubble.
    always_comb begin
        state_nxt = state;
        stall_raw = 1'b0;
        mul_start = 1'b0;
        exmem_d   = '0;
        case (state)
            S_IDLE: begin
                if (bus.Flush) begin
                    state_nxt = S_IDLE;
                end else if (bus.ALUControl == ALU_MUL) begin
                    stall_raw = 1'b1;
                    mul_start = 1'b1;
                    state_nxt = S_BUSY;
                end else begin
                    exmem_d = exmem_live;
                end
            end
            S_BUSY: begin
                if (bus.Flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    stall_raw = 1'b1;
                    if (mul_done) begin
                        state_nxt = S_DONE;
                    end else if (!mul_busy) begin
                        // Multiplier lost its run without a flush; recover rather than hang.
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                // The MUL still sitting in ID/EX retires here and is not restarted.
                state_nxt = S_IDLE;
                if (!bus.Flush) begin
                    exmem_d            = exmem_live;
                    exmem_d.alu_result = mul_product;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    // Stall is forced low while reset is held so upstream is never frozen in reset.
    assign bus.Stall        = stall_raw & rst;
    assign bus.ALUResultOut = exmem_q.alu_result;
    assign bus.WriteDataOut = exmem_q.write_data;
    assign bus.WriteRegOut  = exmem_q.write_reg;
    assign bus.RegWriteOut  = exmem_q.reg_write;
    assign bus.MemReadOut   = exmem_q.mem_read;
    assign bus.MemWriteOut  = exmem_q.mem_write;
    assign bus.MemToRegOut  = exmem_q.mem_to_reg;
    assign bus.TakenOut     = exmem_q.taken;
    assign bus.TargetOut    = exmem_q.target;

endmodule
